// File: rtl/rggen_arbiter_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
`timescale 1ns/1ps
package rggen_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } rggen_arbiter_state_e;

   // A single requester still needs a one-bit index port.
   function automatic int calc_index_width(input int entries);
      return (entries <= 1) ? 1 : $clog2(entries);
   endfunction

endpackage

// File: rtl/rggen_round_robin_picker.sv
// Combinational round-robin pick: first request strictly after the pointer, wrapping at ENTRIES.
`timescale 1ns/1ps
module rggen_round_robin_picker
   import rggen_arbiter_pkg::*;
#(
   parameter int ENTRIES     = 2,
   parameter int INDEX_WIDTH = calc_index_width(ENTRIES)
) (
   input  logic [ENTRIES-1:0]     i_request,
   input  logic [INDEX_WIDTH-1:0] i_pointer,
   output logic [ENTRIES-1:0]     o_pick,
   output logic [INDEX_WIDTH-1:0] o_index,
   output logic                   o_found
);

   logic [2*ENTRIES-1:0] doubled;
   logic [ENTRIES-1:0]   rotated;
   int                   start_idx;
   int                   offset;
   int                   pick_idx;

   // Doubling the vector turns the wrap-around search into a plain slice.
   always_comb begin
      start_idx = (int'(i_pointer) + 1) % ENTRIES;
      doubled   = {i_request, i_request};
      rotated   = doubled[start_idx +: ENTRIES];
      offset    = 0;
      o_found   = 1'b0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            offset  = i;
            o_found = 1'b1;
         end
      end
      pick_idx = (start_idx + offset) % ENTRIES;
      o_index  = INDEX_WIDTH'(pick_idx);
      o_pick   = o_found ? (ENTRIES'(1) << pick_idx) : '0;
   end

endmodule

// File: rtl/rggen_arbiter.sv
// Round-robin arbiter with a registered one-hot grant held until the resource signals done.
`timescale 1ns/1ps
module rggen_arbiter
   import rggen_arbiter_pkg::*;
#(
   parameter int ENTRIES     = 2,
   parameter int INDEX_WIDTH = calc_index_width(ENTRIES)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [ENTRIES-1:0]     i_request,
   input  logic                   i_done,
   output logic [ENTRIES-1:0]     o_grant,
   output logic                   o_grant_valid,
   output logic [INDEX_WIDTH-1:0] o_grant_index,
   output logic                   o_idle
);

   localparam logic [INDEX_WIDTH-1:0] POINTER_INIT = INDEX_WIDTH'(ENTRIES - 1);

   rggen_arbiter_state_e   state_q, state_d;
   logic [ENTRIES-1:0]     grant_q, grant_d;
   logic [INDEX_WIDTH-1:0] index_q, index_d;
   logic [INDEX_WIDTH-1:0] pointer_q, pointer_d;

   logic [INDEX_WIDTH-1:0] search_pointer;
   logic [ENTRIES-1:0]     pick;
   logic [INDEX_WIDTH-1:0] pick_index;
   logic                   pick_found;

   // On a done handover the outgoing index becomes the pointer in the same cycle.
   assign search_pointer = (state_q == BUSY) ? index_q : pointer_q;

   rggen_round_robin_picker #(
      .ENTRIES     (ENTRIES),
      .INDEX_WIDTH (INDEX_WIDTH)
   ) u_picker (
      .i_request (i_request),
      .i_pointer (search_pointer),
      .o_pick    (pick),
      .o_index   (pick_index),
      .o_found   (pick_found)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         index_q   <= '0;
         pointer_q <= POINTER_INIT;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         index_q   <= index_d;
         pointer_q <= pointer_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      index_d   = index_q;
      pointer_d = pointer_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d = pick;
               index_d = pick_index;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (i_done) begin
               pointer_d = index_q;
               if (pick_found) begin
                  grant_d = pick;
                  index_d = pick_index;
               end else begin
                  grant_d = '0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   assign o_grant       = grant_q;
   assign o_grant_valid = (state_q == BUSY);
   assign o_grant_index = index_q;
   assign o_idle        = (state_q == IDLE);

endmodule

// File: tb/tb_rggen_arbiter.sv
// Bench for rggen_arbiter: ENTRIES=4 grant events checked from a queue, plus a directed ENTRIES=1 instance.
`timescale 1ns/1ps
module tb_rggen_arbiter;

   typedef struct packed {
      logic       valid;
      logic [3:0] grant;
      logic [1:0] index;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0;
   logic       done = 1'b0;
   logic [3:0] grant;
   logic       valid;
   logic [1:0] idx;
   logic       idle;

   logic       req1 = 1'b0;
   logic       done1 = 1'b0;
   logic       grant1;
   logic       valid1;
   logic [0:0] idx1;
   logic       idle1;

   exp_t exp_q[$];
   int   n_compared   = 0;
   int   n_mismatched = 0;
   logic prev_valid   = 1'b0;
   logic prev_done    = 1'b0;

   always #5 clk = ~clk;

   rggen_arbiter #(.ENTRIES(4)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_request     (req),
      .i_done        (done),
      .o_grant       (grant),
      .o_grant_valid (valid),
      .o_grant_index (idx),
      .o_idle        (idle)
   );

   rggen_arbiter #(.ENTRIES(1)) dut1 (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_request     (req1),
      .i_done        (done1),
      .o_grant       (grant1),
      .o_grant_valid (valid1),
      .o_grant_index (idx1),
      .o_idle        (idle1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One cycle of inputs, applied just after an edge and sampled at the next.
   task automatic drive(input logic [3:0] r, input logic d);
      step();
      req  = r;
      done = d;
   endtask

   task automatic push_exp(input logic v, input logic [3:0] g, input logic [1:0] i);
      exp_t e;
      e.valid = v;
      e.grant = g;
      e.index = i;
      exp_q.push_back(e);
   endtask

   // A grant event is a fresh grant out of idle or any cycle following a done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_valid = 1'b0;
         prev_done  = 1'b0;
      end else begin
         if ((valid && !prev_valid) || prev_done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_event", {24'd0, valid, idle, grant, idx}, 32'hffff_ffff);
            end else begin
               e = exp_q.pop_front();
               check("grant_event", {24'd0, valid, idle, grant, idx},
                     {24'd0, e.valid, ~e.valid, e.grant, e.index});
               check("grant_onehot", {31'd0, $onehot0(grant)}, 32'd1);
            end
         end
         prev_valid = valid;
         prev_done  = done;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_grant", {28'd0, grant}, 32'd0);
      check("reset_valid", {31'd0, valid}, 32'd0);
      check("reset_index", {30'd0, idx}, 32'd0);
      check("reset_idle",  {31'd0, idle}, 32'd1);
      step();
      rst = 1'b0;

      // First grant from reset pointer, then handover and lone re-grant of requester 3.
      drive(4'b0000, 1'b0);
      drive(4'b1010, 1'b0); push_exp(1'b1, 4'b0010, 2'd1);
      drive(4'b1010, 1'b0);
      drive(4'b1010, 1'b1); push_exp(1'b1, 4'b1000, 2'd3);
      drive(4'b1000, 1'b0);
      drive(4'b1000, 1'b1); push_exp(1'b1, 4'b1000, 2'd3);
      drive(4'b0000, 1'b1); push_exp(1'b0, 4'b0000, 2'd3);
      drive(4'b0000, 1'b0);
      // Stray done while idle changes nothing.
      drive(4'b0000, 1'b1); push_exp(1'b0, 4'b0000, 2'd3);
      drive(4'b0000, 1'b0);

      // Everyone requesting: rotation with done every third cycle.
      drive(4'b1111, 1'b0); push_exp(1'b1, 4'b0001, 2'd0);
      for (int k = 1; k <= 4; k++) begin
         drive(4'b1111, 1'b0);
         drive(4'b1111, 1'b0);
         drive(4'b1111, 1'b1);
         case (k)
            1: push_exp(1'b1, 4'b0010, 2'd1);
            2: push_exp(1'b1, 4'b0100, 2'd2);
            3: push_exp(1'b1, 4'b1000, 2'd3);
            default: push_exp(1'b1, 4'b0001, 2'd0);
         endcase
      end

      // Request changes while busy do not disturb the grant.
      drive(4'b1101, 1'b0);
      drive(4'b1101, 1'b0);
      @(negedge clk);
      check("frozen_grant", {28'd0, grant}, 32'h1);
      check("frozen_index", {30'd0, idx}, 32'd0);
      drive(4'b1101, 1'b1); push_exp(1'b1, 4'b0100, 2'd2);

      // Only requester 2 remains: re-granted without leaving BUSY.
      drive(4'b0100, 1'b0);
      drive(4'b0100, 1'b1); push_exp(1'b1, 4'b0100, 2'd2);
      drive(4'b0100, 1'b0);
      check("regrant_busy", {31'd0, idle}, 32'd0);
      drive(4'b0000, 1'b1); push_exp(1'b0, 4'b0000, 2'd2);
      drive(4'b0000, 1'b0);

      // Pointer is now 2, so 0010 wins; reset mid-transaction must restore pointer 3.
      drive(4'b0010, 1'b0); push_exp(1'b1, 4'b0010, 2'd1);
      drive(4'b0010, 1'b0);
      drive(4'b0010, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_grant", {28'd0, grant}, 32'd0);
      check("async_rst_valid", {31'd0, valid}, 32'd0);
      check("async_rst_index", {30'd0, idx}, 32'd0);
      check("async_rst_idle",  {31'd0, idle}, 32'd1);
      step();
      rst = 1'b0;
      req = 4'b0000;
      drive(4'b1001, 1'b0); push_exp(1'b1, 4'b0001, 2'd0);
      drive(4'b1001, 1'b0);
      drive(4'b0000, 1'b1); push_exp(1'b0, 4'b0000, 2'd0);
      drive(4'b0000, 1'b0);

      // Single-requester instance.
      step();
      req1 = 1'b1;
      @(negedge clk);
      check("e1_latency", {31'd0, grant1}, 32'd0);
      step();
      check("e1_grant", {28'd0, grant1, valid1, idle1, idx1}, 32'b1100);
      done1 = 1'b1;
      step();
      done1 = 1'b0;
      check("e1_regrant", {29'd0, grant1, valid1, idle1}, 32'b110);
      #2 rst = 1'b1;
      #1;
      check("e1_async_rst", {29'd0, grant1, valid1, idle1}, 32'b001);
      step();
      rst = 1'b0;
      step();
      check("e1_after_rst", {29'd0, grant1, valid1, idle1}, 32'b110);
      req1  = 1'b0;
      done1 = 1'b1;
      step();
      done1 = 1'b0;
      check("e1_release", {29'd0, grant1, valid1, idle1}, 32'b001);

      repeat (3) step();
      check("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
